// File: rtl/tracker_sequencer.sv
// Pattern sequencer for the tracker voice: steps through a small note memory at a
// programmable tempo and presents each row's note word and speed with start/stop/loop control.
module tracker_sequencer #(
  parameter int ROWS     = 16,
  parameter int ADDR_W   = 4,
  parameter int TICK_DIV = 64,
  parameter int TICK_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [3:0]        tempo,
  output logic [15:0]       note,
  output logic [3:0]        speed,
  output logic [ADDR_W-1:0] row,
  output logic              row_stb,
  output logic              playing,
  output logic              done
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] row_reg, row_next;
  logic [15:0]       note_reg, note_next;
  logic [3:0]        speed_reg, speed_next;
  logic              stb_reg, stb_next;
  logic              done_reg, done_next;
  logic [TICK_W-1:0] div_reg, div_next;
  logic [3:0]        tick_reg, tick_next;

  logic [15:0]       mem [ROWS];

  // Pattern memory has no reset so its contents survive a mid-playback reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  logic [3:0]        eff_tempo;
  logic              last_div;
  logic              row_end;
  logic [ADDR_W-1:0] next_row;
  logic [15:0]       next_word;

  assign eff_tempo = (tempo == 4'd0) ? 4'd1 : tempo;
  assign last_div  = (div_reg == TICK_W'(TICK_DIV - 1));
  // speed_reg holds the tempo latched at row start, so mid-row tempo changes are ignored.
  assign row_end   = last_div && (tick_reg == speed_reg - 4'd1);
  assign next_row  = row_reg + ADDR_W'(1);
  assign next_word = mem[next_row];

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    note_next  = note_reg;
    speed_next = speed_reg;
    stb_next   = 1'b0;
    done_next  = 1'b0;
    div_next   = div_reg;
    tick_next  = tick_reg;

    if (stop) begin
      state_next = IDLE;
      note_next  = 16'd0;
      speed_next = 4'd0;
      div_next   = '0;
      tick_next  = 4'd0;
    end else if (start) begin
      state_next = PLAY;
      row_next   = '0;
      note_next  = mem[0];
      speed_next = eff_tempo;
      stb_next   = 1'b1;
      div_next   = '0;
      tick_next  = 4'd0;
    end else if (state_reg == PLAY) begin
      if (last_div) begin
        div_next  = '0;
        tick_next = tick_reg + 4'd1;
      end else begin
        div_next  = div_reg + TICK_W'(1);
      end

      if (row_end) begin
        div_next  = '0;
        tick_next = 4'd0;
        // next_row wraps to 0 from the last row, which is exactly the loop target.
        if ((row_reg != ADDR_W'(ROWS - 1)) || loop) begin
          row_next   = next_row;
          speed_next = eff_tempo;
          stb_next   = 1'b1;
          if (next_word != 16'd0) note_next = next_word;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
          note_next  = 16'd0;
          speed_next = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      note_reg  <= 16'd0;
      speed_reg <= 4'd0;
      stb_reg   <= 1'b0;
      done_reg  <= 1'b0;
      div_reg   <= '0;
      tick_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      note_reg  <= note_next;
      speed_reg <= speed_next;
      stb_reg   <= stb_next;
      done_reg  <= done_next;
      div_reg   <= div_next;
      tick_reg  <= tick_next;
    end
  end

  assign note    = note_reg;
  assign speed   = speed_reg;
  assign row     = row_reg;
  assign row_stb = stb_reg;
  assign playing = (state_reg == PLAY);
  assign done    = done_reg;

endmodule

// File: tb/tb_tracker_sequencer.sv
// Self-checking bench for tracker_sequencer (4 rows, 4 clocks per tick) against a
// countdown-based behavioural model of playback.
module tb_tracker_sequencer;

  localparam int ROWS = 4;
  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start, stop, loop;
  logic [3:0]  tempo;
  logic [15:0] note;
  logic [3:0]  speed;
  logic [1:0]  row;
  logic        row_stb, playing, done;

  int errors = 0;
  int checks = 0;

  tracker_sequencer #(.ROWS(4), .ADDR_W(2), .TICK_DIV(4), .TICK_W(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .tempo(tempo),
    .note(note), .speed(speed), .row(row), .row_stb(row_stb),
    .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: a row lasts eff*TDIV edges, tracked as a countdown.
  logic [15:0] m_mem [ROWS];
  logic [15:0] m_note;
  int          m_speed, m_row, m_left;
  bit          m_play, m_stb, m_done;

  function automatic int eff(input logic [3:0] t);
    return (t == 4'd0) ? 1 : int'(t);
  endfunction

  function automatic logic [24:0] dut_v();
    return {note, speed, row, row_stb, playing, done};
  endfunction

  function automatic logic [24:0] mod_v();
    return {m_note, 4'(m_speed), 2'(m_row), m_stb, m_play, m_done};
  endfunction

  task automatic model_reset();
    m_note = 16'd0; m_speed = 0; m_row = 0; m_left = 0;
    m_play = 0; m_stb = 0; m_done = 0;
  endtask

  // Drive one cycle of inputs, advance one clock edge, update the model, settle.
  task automatic step(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                      input logic st, input logic sp);
    wr_en = we; wr_addr = wa; wr_data = wd; start = st; stop = sp;
    @(posedge clk);
    m_stb = 0; m_done = 0;
    if (sp) begin
      m_play = 0; m_note = 16'd0; m_speed = 0;
    end else if (st) begin
      m_play = 1; m_row = 0; m_note = m_mem[0];
      m_speed = eff(tempo); m_left = m_speed * TDIV; m_stb = 1;
    end else if (m_play) begin
      m_left--;
      if (m_left == 0) begin
        if (m_row < ROWS - 1 || loop) begin
          m_row = (m_row + 1) % ROWS;
          if (m_mem[m_row] != 16'd0) m_note = m_mem[m_row];
          m_speed = eff(tempo); m_left = m_speed * TDIV; m_stb = 1;
        end else begin
          m_play = 0; m_done = 1; m_note = 16'd0; m_speed = 0;
        end
      end
    end
    if (we) m_mem[wa] = wd;
    #1;
    wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    if (row_stb) $display("row %0d note %h speed %0d", row, note, speed);
    if (done)    $display("done");
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; stop = 0;
    loop = 0; tempo = 0;
    model_reset();
    for (int i = 0; i < ROWS; i++) m_mem[i] = 16'd0;
    #12;
    checks++;
    if (dut_v() !== 25'd0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_v(), 25'd0);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_play_once();
    logic [15:0] words [4];
    int stbs, done_at;
    words[0] = 16'h1234; words[1] = 16'h2345; words[2] = 16'h3456; words[3] = 16'h4567;
    for (int i = 0; i < ROWS; i++) step(1'b1, 2'(i), words[i], 1'b0, 1'b0);
    loop = 0; tempo = 4'd2;
    stbs = 0; done_at = -1;
    for (int i = 0; i < 36; i++) begin
      step(1'b0, 2'd0, 16'd0, (i == 0), 1'b0);
      checks++;
      if (dut_v() !== mod_v()) begin
        errors++; $display("FAIL play_once cyc %0d: got %h expected %h", i, dut_v(), mod_v());
      end
      if (row_stb) begin
        checks++;
        if (i != stbs * 8 || row !== 2'(stbs) || note !== words[stbs] || speed !== 4'd2) begin
          errors++;
          $display("FAIL play_once_row cyc %0d: got row %0d note %h speed %0d expected row %0d note %h speed 2",
                   i, row, note, speed, stbs, words[stbs & 3]);
        end
        stbs++;
      end
      if (done) done_at = i;
    end
    checks++;
    if (stbs != 4 || done_at != 32 || note !== 16'd0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL play_once_end: got strobes %0d done_at %0d note %h playing %b expected 4 32 0000 0",
               stbs, done_at, note, playing);
    end
  endtask

  task automatic test_loop_stop();
    loop = 1; tempo = 4'd2;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 2'd0, 16'd0, (i == 0), 1'b0);
      checks++;
      if (dut_v() !== mod_v() || done !== 1'b0) begin
        errors++; $display("FAIL loop cyc %0d: got %h expected %h", i, dut_v(), mod_v());
      end
      if (i == 32) begin
        checks++;
        if (row_stb !== 1'b1 || row !== 2'd0 || note !== 16'h1234) begin
          errors++;
          $display("FAIL loop_wrap: got stb %b row %0d note %h expected 1 0 1234", row_stb, row, note);
        end
      end
    end
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
    checks++;
    if (note !== 16'd0 || playing !== 1'b0 || done !== 1'b0 || dut_v() !== mod_v()) begin
      errors++; $display("FAIL loop_stop: got %h expected %h", dut_v(), mod_v());
    end
    loop = 0;
  endtask

  task automatic test_sustain();
    step(1'b1, 2'd1, 16'h0000, 1'b0, 1'b0);
    loop = 0; tempo = 4'd2;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'd0, 16'd0, (i == 0), 1'b0);
      checks++;
      if (dut_v() !== mod_v()) begin
        errors++; $display("FAIL sustain cyc %0d: got %h expected %h", i, dut_v(), mod_v());
      end
      if (i == 8 || i == 16) begin
        checks++;
        if (row_stb !== 1'b1 || note !== ((i == 8) ? 16'h1234 : 16'h3456)) begin
          errors++; $display("FAIL sustain_row cyc %0d: got stb %b note %h", i, row_stb, note);
        end
      end
    end
    step(1'b1, 2'd1, 16'h2345, 1'b0, 1'b1);
  endtask

  task automatic test_tempo();
    loop = 0; tempo = 4'd0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'd0, 16'd0, (i == 0), 1'b0);
      checks++;
      if (dut_v() !== mod_v()) begin
        errors++; $display("FAIL tempo0 cyc %0d: got %h expected %h", i, dut_v(), mod_v());
      end
      if (i == 4) begin
        checks++;
        if (row_stb !== 1'b1 || row !== 2'd1 || speed !== 4'd1) begin
          errors++; $display("FAIL tempo0_len: got stb %b row %0d speed %0d expected 1 1 1", row_stb, row, speed);
        end
      end
    end
    tempo = 4'd1;
    for (int i = 0; i < 18; i++) begin
      if (i == 3) tempo = 4'd3;
      step(1'b0, 2'd0, 16'd0, (i == 0), 1'b0);
      checks++;
      if (dut_v() !== mod_v()) begin
        errors++; $display("FAIL tempo_chg cyc %0d: got %h expected %h", i, dut_v(), mod_v());
      end
      if (i == 4 || i == 16) begin
        checks++;
        if (row_stb !== 1'b1 || speed !== 4'd3 || row !== ((i == 4) ? 2'd1 : 2'd2)) begin
          errors++; $display("FAIL tempo_chg_len cyc %0d: got stb %b row %0d speed %0d", i, row_stb, row, speed);
        end
      end
    end
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_start_stop();
    tempo = 4'd2; loop = 0;
    for (int i = 0; i < 18; i++) step(1'b0, 2'd0, 16'd0, (i == 0), 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b1);
    checks++;
    if (playing !== 1'b0 || note !== 16'd0 || row_stb !== 1'b0 || dut_v() !== mod_v()) begin
      errors++; $display("FAIL start_stop: got %h expected %h", dut_v(), mod_v());
    end
    for (int i = 0; i < 18; i++) step(1'b0, 2'd0, 16'd0, (i == 0), 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
    checks++;
    if (row !== 2'd0 || row_stb !== 1'b1 || note !== 16'h1234 || dut_v() !== mod_v()) begin
      errors++; $display("FAIL restart: got %h expected %h", dut_v(), mod_v());
    end
  endtask

  task automatic test_back_to_back_reset();
    tempo = 4'd2; loop = 0;
    for (int i = 0; i < 18; i++) step(1'b0, 2'd0, 16'd0, (i == 0), 1'b0);
    #2; rst = 1'b1; #1;
    model_reset();
    checks++;
    if (dut_v() !== 25'd0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", dut_v(), 25'd0);
    end
    @(negedge clk); rst = 1'b0;
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
    checks++;
    if (note !== 16'h1234 || row_stb !== 1'b1 || dut_v() !== mod_v()) begin
      errors++; $display("FAIL mem_retained: got %h expected %h", dut_v(), mod_v());
    end
    for (int i = 1; i < 8; i++) step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 16'hBEEF, 1'b0, 1'b0);
    checks++;
    if (row !== 2'd1 || row_stb !== 1'b1 || note !== 16'h2345 || dut_v() !== mod_v()) begin
      errors++; $display("FAIL read_before_write: got %h expected %h", dut_v(), mod_v());
    end
  endtask

  task automatic test_random();
    logic [15:0] wd;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15, 0) == 0) tempo = 4'($urandom_range(3, 0));
      if ($urandom_range(31, 0) == 0) loop = ~loop;
      wd = ($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom);
      step(($urandom_range(7, 0) == 0), 2'($urandom_range(3, 0)), wd,
           ($urandom_range(39, 0) == 0), ($urandom_range(79, 0) == 0));
      checks++;
      if (dut_v() !== mod_v()) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_v(), mod_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_play_once();
    test_loop_stop();
    test_sustain();
    test_tempo();
    test_start_stop();
    test_back_to_back_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
